// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle main FSM and the datapath it steers.
// The master side is the controller: it observes the instruction opcode and
// the memory ready flag, and drives every datapath enable and mux select.
interface multicycle_control_if;

    // Inputs to the controller
    logic [5:0] opcode;         // instruction bits [31:26] from the IR
    logic       mem_ready;      // memory has completed the current access

    // Controller outputs
    logic       pc_write;       // unconditional PC load
    logic       pc_write_cond;  // PC load qualified by ALU zero outside
    logic       i_or_d;         // memory address: 0 = PC, 1 = ALUOut
    logic       mem_read;       // memory read request
    logic       mem_write;      // memory write request
    logic       ir_write;       // instruction register load
    logic       mem_to_reg;     // reg write data: 1 = MDR, 0 = ALUOut
    logic       reg_dst;        // destination: 1 = rd, 0 = rt
    logic       reg_write;      // register file write enable
    logic       alu_src_a;      // ALU A: 0 = PC, 1 = register A
    logic [1:0] alu_src_b;      // ALU B: B / 4 / imm / imm<<2
    logic [1:0] alu_op;         // 00 add, 01 subtract, 10 decode funct
    logic [1:0] pc_source;      // 00 ALU result, 01 ALUOut, 10 jump target
    logic       instr_done;     // one-cycle pulse when an instruction retires
    logic       illegal_op;     // one-cycle pulse on an unsupported opcode
    logic [3:0] state;          // current FSM state, for debug

    modport master (
        input  opcode,
        input  mem_ready,
        output pc_write,
        output pc_write_cond,
        output i_or_d,
        output mem_read,
        output mem_write,
        output ir_write,
        output mem_to_reg,
        output reg_dst,
        output reg_write,
        output alu_src_a,
        output alu_src_b,
        output alu_op,
        output pc_source,
        output instr_done,
        output illegal_op,
        output state
    );

    modport slave (
        output opcode,
        output mem_ready,
        input  pc_write,
        input  pc_write_cond,
        input  i_or_d,
        input  mem_read,
        input  mem_write,
        input  ir_write,
        input  mem_to_reg,
        input  reg_dst,
        input  reg_write,
        input  alu_src_a,
        input  alu_src_b,
        input  alu_op,
        input  pc_source,
        input  instr_done,
        input  illegal_op,
        input  state
    );

endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// One instruction at a time is walked through fetch, decode, execute, memory
// and writeback. Outputs are a Moore decode of the state register, except the
// FETCH load enables and the MEMWR retire pulse, which follow mem_ready so a
// stalled access commits nothing until memory reports completion.
module multicycle_control (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_control_if.master   bus
);

    // Opcodes understood by the controller
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALU B source selects
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // ALU operation classes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // PC source selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Encodings 13..15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_RWB     = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_ADDI_EX = 4'd11,
        S_ADDI_WB = 4'd12
    } state_e;

    // Map an opcode to the state that follows DECODE; FETCH marks an
    // unsupported opcode, which the caller flags as illegal.
    function automatic state_e decode_target(input logic [5:0] op);
        state_e tgt;
        case (op)
            OP_LW:    tgt = S_MEMADR;
            OP_SW:    tgt = S_MEMADR;
            OP_RTYPE: tgt = S_EXEC;
            OP_BEQ:   tgt = S_BRANCH;
            OP_J:     tgt = S_JUMP;
            OP_ADDI:  tgt = S_ADDI_EX;
            default:  tgt = S_FETCH;
        endcase
        return tgt;
    endfunction

    state_e state_q;
    state_e state_d;

    // Combinational output values before they are placed on the bus
    logic       pc_write_s;
    logic       pc_write_cond_s;
    logic       i_or_d_s;
    logic       mem_read_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       mem_to_reg_s;
    logic       reg_dst_s;
    logic       reg_write_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic [1:0] pc_source_s;
    logic       instr_done_s;
    logic       illegal_op_s;

    // State register with synchronous reset to IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; memory states hold until mem_ready is seen
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                state_d = decode_target(bus.opcode);
            end
            S_MEMADR: begin
                // Only lw/sw reach here; anything else restarts the fetch
                if (bus.opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (bus.opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMWB: begin
                state_d = S_FETCH;
            end
            S_MEMWR: begin
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_EXEC: begin
                state_d = S_RWB;
            end
            S_RWB: begin
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                state_d = S_FETCH;
            end
            S_JUMP: begin
                state_d = S_FETCH;
            end
            S_ADDI_EX: begin
                state_d = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Output decode: every signal defaults low, each state raises its own set
    always_comb begin
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        i_or_d_s        = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        mem_to_reg_s    = 1'b0;
        reg_dst_s       = 1'b0;
        reg_write_s     = 1'b0;
        alu_src_a_s     = 1'b0;
        alu_src_b_s     = SRCB_REG;
        alu_op_s        = ALUOP_ADD;
        pc_source_s     = PCSRC_ALU;
        instr_done_s    = 1'b0;
        illegal_op_s    = 1'b0;
        case (state_q)
            S_IDLE: begin
                pc_write_s = 1'b0;
            end
            S_FETCH: begin
                // PC+4 goes through the ALU; IR and PC load only on completion
                mem_read_s  = 1'b1;
                i_or_d_s    = 1'b0;
                alu_src_a_s = 1'b0;
                alu_src_b_s = SRCB_FOUR;
                alu_op_s    = ALUOP_ADD;
                pc_source_s = PCSRC_ALU;
                ir_write_s  = bus.mem_ready;
                pc_write_s  = bus.mem_ready;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut while registers read
                alu_src_a_s = 1'b0;
                alu_src_b_s = SRCB_IMMSH;
                alu_op_s    = ALUOP_ADD;
                if (decode_target(bus.opcode) == S_FETCH) begin
                    illegal_op_s = 1'b1;
                end else begin
                    illegal_op_s = 1'b0;
                end
            end
            S_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_IMM;
                alu_op_s    = ALUOP_ADD;
            end
            S_MEMRD: begin
                mem_read_s = 1'b1;
                i_or_d_s   = 1'b1;
            end
            S_MEMWB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
                reg_dst_s    = 1'b0;
                instr_done_s = 1'b1;
            end
            S_MEMWR: begin
                // The store retires in the cycle memory accepts it
                mem_write_s  = 1'b1;
                i_or_d_s     = 1'b1;
                instr_done_s = bus.mem_ready;
            end
            S_EXEC: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_REG;
                alu_op_s    = ALUOP_FUNCT;
            end
            S_RWB: begin
                reg_write_s  = 1'b1;
                reg_dst_s    = 1'b1;
                mem_to_reg_s = 1'b0;
                instr_done_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_s     = 1'b1;
                alu_src_b_s     = SRCB_REG;
                alu_op_s        = ALUOP_SUB;
                pc_write_cond_s = 1'b1;
                pc_source_s     = PCSRC_ALUOUT;
                instr_done_s    = 1'b1;
            end
            S_JUMP: begin
                pc_write_s   = 1'b1;
                pc_source_s  = PCSRC_JUMP;
                instr_done_s = 1'b1;
            end
            S_ADDI_EX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_IMM;
                alu_op_s    = ALUOP_ADD;
            end
            S_ADDI_WB: begin
                reg_write_s  = 1'b1;
                reg_dst_s    = 1'b0;
                mem_to_reg_s = 1'b0;
                instr_done_s = 1'b1;
            end
            default: begin
                pc_write_s = 1'b0;
            end
        endcase
    end

    assign bus.pc_write      = pc_write_s;
    assign bus.pc_write_cond = pc_write_cond_s;
    assign bus.i_or_d        = i_or_d_s;
    assign bus.mem_read      = mem_read_s;
    assign bus.mem_write     = mem_write_s;
    assign bus.ir_write      = ir_write_s;
    assign bus.mem_to_reg    = mem_to_reg_s;
    assign bus.reg_dst       = reg_dst_s;
    assign bus.reg_write     = reg_write_s;
    assign bus.alu_src_a     = alu_src_a_s;
    assign bus.alu_src_b     = alu_src_b_s;
    assign bus.alu_op        = alu_op_s;
    assign bus.pc_source     = pc_source_s;
    assign bus.instr_done    = instr_done_s;
    assign bus.illegal_op    = illegal_op_s;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control. Each stimulus step sets the inputs
// for one cycle and queues the state and control word expected in that cycle;
// a monitor on the falling edge pops and compares.
module tb_multicycle_control;

    logic clk;
    logic reset;

    multicycle_control_if bus_if();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Opcodes
    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_ADI = 6'b001000;
    localparam logic [5:0] OP_BAD = 6'b111111;

    // Control word, MSB first:
    // pc_write pc_write_cond i_or_d mem_read mem_write ir_write _
    // mem_to_reg reg_dst reg_write alu_src_a _ alu_src_b alu_op pc_source _
    // instr_done illegal_op
    localparam logic [17:0] O_IDLE    = 18'b000000_0000_000000_00;
    localparam logic [17:0] O_FETCH_R = 18'b100101_0000_010000_00;
    localparam logic [17:0] O_FETCH_S = 18'b000100_0000_010000_00;
    localparam logic [17:0] O_DECODE  = 18'b000000_0000_110000_00;
    localparam logic [17:0] O_DEC_ILL = 18'b000000_0000_110000_01;
    localparam logic [17:0] O_MEMADR  = 18'b000000_0001_100000_00;
    localparam logic [17:0] O_MEMRD   = 18'b001100_0000_000000_00;
    localparam logic [17:0] O_MEMWB   = 18'b000000_1010_000000_10;
    localparam logic [17:0] O_MEMWR_S = 18'b001010_0000_000000_00;
    localparam logic [17:0] O_MEMWR_R = 18'b001010_0000_000000_10;
    localparam logic [17:0] O_EXEC    = 18'b000000_0001_001000_00;
    localparam logic [17:0] O_RWB     = 18'b000000_0110_000000_10;
    localparam logic [17:0] O_BRANCH  = 18'b010000_0001_000101_10;
    localparam logic [17:0] O_JUMP    = 18'b100000_0000_000010_10;
    localparam logic [17:0] O_ADDI_EX = 18'b000000_0001_100000_00;
    localparam logic [17:0] O_ADDI_WB = 18'b000000_0010_000000_10;

    typedef struct packed {
        int          id;
        logic [3:0]  st;
        logic [17:0] o;
    } exp_t;

    exp_t exp_q[$];
    int   step_id;
    logic stim_done;
    int   n_run;
    int   n_fail;

    // Drive one cycle of inputs and queue the expected response for it
    task automatic step(input logic r, input logic [5:0] op, input logic rdy,
                        input logic [3:0] st, input logic [17:0] o);
        exp_t e;
        reset            = r;
        bus_if.opcode    = op;
        bus_if.mem_ready = rdy;
        e.id = step_id;
        e.st = st;
        e.o  = o;
        exp_q.push_back(e);
        step_id = step_id + 1;
        @(posedge clk);
        #1;
    endtask

    // Stimulus: directed instruction sequences
    initial begin
        step_id          = 0;
        stim_done        = 1'b0;
        reset            = 1'b1;
        bus_if.opcode    = OP_R;
        bus_if.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        // Reset held: IDLE, all zero; release -> FETCH next
        step(1'b0, OP_LW, 1'b1, 4'd0, O_IDLE);
        // lw with memory ready: 1,2,3,4,5
        step(1'b0, OP_LW, 1'b1, 4'd1, O_FETCH_R);
        step(1'b0, OP_LW, 1'b1, 4'd2, O_DECODE);
        step(1'b0, OP_LW, 1'b1, 4'd3, O_MEMADR);
        step(1'b0, OP_LW, 1'b1, 4'd4, O_MEMRD);
        step(1'b0, OP_LW, 1'b1, 4'd5, O_MEMWB);
        // R-type (funct sub): 1,2,7,8; mem_ready ignored in DECODE/EXEC
        step(1'b0, OP_R, 1'b1, 4'd1, O_FETCH_R);
        step(1'b0, OP_R, 1'b0, 4'd2, O_DECODE);
        step(1'b0, OP_R, 1'b0, 4'd7, O_EXEC);
        step(1'b0, OP_R, 1'b1, 4'd8, O_RWB);
        // sw, store stalls 3 cycles
        step(1'b0, OP_SW, 1'b1, 4'd1, O_FETCH_R);
        step(1'b0, OP_SW, 1'b1, 4'd2, O_DECODE);
        step(1'b0, OP_SW, 1'b1, 4'd3, O_MEMADR);
        step(1'b0, OP_SW, 1'b0, 4'd6, O_MEMWR_S);
        step(1'b0, OP_SW, 1'b0, 4'd6, O_MEMWR_S);
        step(1'b0, OP_SW, 1'b0, 4'd6, O_MEMWR_S);
        step(1'b0, OP_SW, 1'b1, 4'd6, O_MEMWR_R);
        // addi with a 2-cycle fetch stall
        step(1'b0, OP_ADI, 1'b0, 4'd1, O_FETCH_S);
        step(1'b0, OP_ADI, 1'b0, 4'd1, O_FETCH_S);
        step(1'b0, OP_ADI, 1'b1, 4'd1, O_FETCH_R);
        step(1'b0, OP_ADI, 1'b0, 4'd2, O_DECODE);
        step(1'b0, OP_ADI, 1'b0, 4'd11, O_ADDI_EX);
        step(1'b0, OP_ADI, 1'b0, 4'd12, O_ADDI_WB);
        // beq
        step(1'b0, OP_BEQ, 1'b1, 4'd1, O_FETCH_R);
        step(1'b0, OP_BEQ, 1'b1, 4'd2, O_DECODE);
        step(1'b0, OP_BEQ, 1'b1, 4'd9, O_BRANCH);
        // j
        step(1'b0, OP_J, 1'b1, 4'd1, O_FETCH_R);
        step(1'b0, OP_J, 1'b1, 4'd2, O_DECODE);
        step(1'b0, OP_J, 1'b1, 4'd10, O_JUMP);
        // unsupported opcode: illegal pulse in DECODE, back to FETCH
        step(1'b0, OP_BAD, 1'b1, 4'd1, O_FETCH_R);
        step(1'b0, OP_BAD, 1'b1, 4'd2, O_DEC_ILL);
        // lw stalled in MEMRD, then reset for two cycles
        step(1'b0, OP_LW, 1'b1, 4'd1, O_FETCH_R);
        step(1'b0, OP_LW, 1'b1, 4'd2, O_DECODE);
        step(1'b0, OP_LW, 1'b1, 4'd3, O_MEMADR);
        step(1'b0, OP_LW, 1'b0, 4'd4, O_MEMRD);
        step(1'b1, OP_LW, 1'b0, 4'd4, O_MEMRD);
        step(1'b1, OP_LW, 1'b0, 4'd0, O_IDLE);
        step(1'b0, OP_LW, 1'b0, 4'd0, O_IDLE);
        step(1'b0, OP_LW, 1'b0, 4'd1, O_FETCH_S);
        step(1'b0, OP_LW, 1'b1, 4'd1, O_FETCH_R);
        step(1'b0, OP_LW, 1'b1, 4'd2, O_DECODE);
        stim_done = 1'b1;
    end

    // Monitor: compare each queued expectation on the falling edge
    initial begin
        exp_t        e;
        logic [17:0] act_o;
        int          drain;
        n_run  = 0;
        n_fail = 0;
        drain  = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act_o = {bus_if.pc_write, bus_if.pc_write_cond, bus_if.i_or_d,
                         bus_if.mem_read, bus_if.mem_write, bus_if.ir_write,
                         bus_if.mem_to_reg, bus_if.reg_dst, bus_if.reg_write,
                         bus_if.alu_src_a, bus_if.alu_src_b, bus_if.alu_op,
                         bus_if.pc_source, bus_if.instr_done, bus_if.illegal_op};
                n_run = n_run + 1;
                if (bus_if.state !== e.st || act_o !== e.o) begin
                    n_fail = n_fail + 1;
                    $display("FAIL step%0d: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                             e.id, bus_if.state, act_o, e.st, e.o);
                end
            end else if (stim_done) begin
                $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
                $finish;
            end
            if (stim_done) begin
                drain = drain + 1;
                if (drain > 8) begin
                    n_run  = n_run + 1;
                    n_fail = n_fail + 1;
                    $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
                    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
                    $finish;
                end
            end
        end
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control finite-state machine for the multicycle MIPS datapath. It sequences one instruction at a time through fetch, decode, execute, memory and writeback, and drives every datapath enable and mux select. It also drives the 2-bit ALU-operation class that the ALU control decoder expands, together with the funct field, into the 4-bit ALU control code. Memory accesses stall on a ready handshake, so the same FSM serves both single-cycle-latency memory and slower memory.

## Interface
Parameters:
- none (opcode values and state encodings are fixed, listed below)

Ports:
- clk  input  1  system clock; all state changes occur on its rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  6  instruction bits [31:26], taken from the instruction register
- mem_ready  input  1  memory has completed the current access
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load qualified externally by the ALU zero flag
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  instruction register load
- mem_to_reg  output  1  register write-data select: 1 = MDR, 0 = ALUOut
- reg_dst  output  1  destination register select: 1 = rd, 0 = rt
- reg_write  output  1  register file write enable
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = register A
- alu_src_b  output  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2
- alu_op  output  2  to the ALU control decoder: 00 = add, 01 = subtract, 10 = decode funct
- pc_source  output  2  PC source select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  output  1  one-cycle pulse when an instruction retires
- illegal_op  output  1  one-cycle pulse when an unsupported opcode is decoded
- state  output  4  current state, for debug

## Operation
State encodings:
- IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BRANCH=9, JUMP=10, ADDI_EX=11, ADDI_WB=12.
- Encodings 13-15 are unused; any of them transitions to FETCH on the next edge.

Supported opcodes:
- R-type = 000000
- lw = 100011
- sw = 101011
- beq = 000100
- j = 000010
- addi = 001000

Output decode:
- Outputs are a Moore decode of `state`, except where a signal is explicitly gated by mem_ready.
- Every output not listed for a state is 0.

Per-state outputs and transitions:
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write are both equal to mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target).
  - lw or sw: go to MEMADR.
  - R-type: go to EXEC.
  - beq: go to BRANCH.
  - j: go to JUMP.
  - addi: go to ADDI_EX.
  - any other opcode: illegal_op=1 for this cycle, then go to FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD if opcode is lw, MEMWR if opcode is sw.
- MEMRD: mem_read=1, i_or_d=1. Stay while mem_ready=0; go to MEMWB when mem_ready=1.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Go to FETCH.
- MEMWR: mem_write=1, i_or_d=1. instr_done equals mem_ready. Stay while mem_ready=0; go to FETCH when mem_ready=1.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Go to FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Go to FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Go to ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Go to FETCH.

## Timing
Reset:
- Synchronous: reset=1 at a rising edge forces state=IDLE, whatever the current state, including mid-stall in FETCH, MEMRD or MEMWR.
- While in IDLE every output is 0.
- After reset is released, the first FETCH occurs one cycle later.

Cycles per instruction, with mem_ready held at 1:
- lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.
- Each cycle mem_ready=0 spends in FETCH, MEMRD or MEMWR adds exactly one cycle.

Handshake and boundary rules:
- Memory requests are held steady until the cycle in which mem_ready=1 is sampled.
- mem_ready is ignored in all states other than FETCH, MEMRD and MEMWR.
- mem_read and mem_write are never both 1 in the same cycle.
- pc_write and pc_write_cond are never both 1 in the same cycle.
- instr_done is a single-cycle pulse per instruction.
- In MEMADR an opcode that is neither lw nor sw cannot occur by construction. If it does, go to FETCH.

## Test plan
- Reset: assert reset for 2 cycles while the FSM is in MEMRD with mem_ready=0 -> state=0 and all outputs 0; FETCH (state=1) follows one cycle after reset is released.
- lw, mem_ready=1 throughout -> state sequence 1,2,3,4,5. In MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next state is FETCH.
- R-type with funct 100010 -> sequence 1,2,7,8. alu_op=10 in EXEC; reg_write=1 and reg_dst=1 in RWB. Total 4 cycles.
- sw with mem_ready low for 3 cycles in MEMWR -> mem_write=1 and i_or_d=1 held for 4 cycles. instr_done pulses exactly once, in the ready cycle.
- FETCH stall: mem_ready=0 for 2 cycles -> ir_write=0 and pc_write=0 in those cycles; both are 1 only in the third cycle, followed by DECODE.
- beq, j and opcode 111111 in turn:
  - beq -> BRANCH with pc_write_cond=1, pc_source=01, alu_op=01.
  - j -> JUMP with pc_write=1, pc_source=10.
  - 111111 -> illegal_op pulses in DECODE, then FETCH with no instr_done pulse.
